// File: rtl/membus_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : membus_arb_pkg                                             |
// | Description : Shared types and helpers for the membus N:1 arbiter.       |
// |               Provides the master-id type for the default two-master     |
// |               build, the id-width helper and the cyclic find-first used  |
// |               for both round-robin and fixed-priority selection.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package membus_arb_pkg;

  // Upper bound on channels the find-first helper can scan.
  localparam int unsigned RR_MAX_MASTERS = 32;

  // Master id for the default NUM_MASTERS=2 build; parameterised builds
  // derive their own width through id_width().
  typedef logic [0:0] master_id_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First asserted request at or after ptr, scanning cyclically over the
  // n low bits of req. With ptr=0 this is a plain lowest-index pick, which
  // is exactly fixed priority. Returns ptr when nothing is requested.
  function automatic int unsigned rr_find_first(
    input logic [RR_MAX_MASTERS-1:0] req,
    input int unsigned               ptr,
    input int unsigned               n
  );
    int unsigned idx;
    logic        found;
    rr_find_first = ptr;
    found         = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_MASTERS; k++) begin
      if (!found && (k < n)) begin
        // ptr < n and k < n, so one conditional subtract gives the wrap.
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) begin
          rr_find_first = idx;
          found         = 1'b1;
        end
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/membus_arb_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : membus_arb_tracker                                         |
// | Description : In-order outstanding-request tracker. Synchronous FIFO of  |
// |               master ids: one entry per accepted request, popped by each |
// |               slave response so the response can be routed back.        |
// | Ports       : clk, rst (sync, active-high); push/push_id enqueue;        |
// |               pop dequeues; full/empty status; head = oldest entry.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module membus_arb_tracker #(
  parameter int unsigned ID_W  = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [ID_W-1:0] head
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : membus_arbiter                                             |
// | Description : N-master to 1-slave membus arbiter. Zero-latency request   |
// |               mux with round-robin or fixed-priority grant, grant hold   |
// |               while the slave stalls, and in-order response routing for  |
// |               up to MAX_OUTSTANDING requests in flight.                  |
// | Ports       : clk, rst (sync, active-high)                               |
// |               m_* : per-master request (flattened) and response          |
// |               s_* : single slave request and response                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module membus_arbiter
  import membus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          ROUND_ROBIN     = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS-1:0]                m_valid,
  output logic [NUM_MASTERS-1:0]                m_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr,
  input  logic [NUM_MASTERS-1:0]                m_wen,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_wmask,
  output logic [NUM_MASTERS-1:0]                m_rvalid,
  output logic [DATA_WIDTH-1:0]                 m_rdata,
  output logic                                  s_valid,
  output logic [ADDR_WIDTH-1:0]                 s_addr,
  output logic                                  s_wen,
  output logic [DATA_WIDTH-1:0]                 s_wdata,
  output logic [DATA_WIDTH/8-1:0]               s_wmask,
  input  logic                                  s_ready,
  input  logic                                  s_rvalid,
  input  logic [DATA_WIDTH-1:0]                 s_rdata
);

  localparam int unsigned ID_W   = id_width(NUM_MASTERS);
  localparam int unsigned MASK_W = DATA_WIDTH / 8;

  typedef logic [ID_W-1:0] mid_t;
  localparam mid_t LAST_ID = mid_t'(NUM_MASTERS - 1);

  logic lock_q,    lock_d;
  mid_t lock_id_q, lock_id_d;
  mid_t rr_ptr_q,  rr_ptr_d;

  mid_t gnt, rr_pick, fp_pick, head;
  logic full, empty, accept, stall;

  assign rr_pick = mid_t'(rr_find_first(RR_MAX_MASTERS'(m_valid), 32'(rr_ptr_q), NUM_MASTERS));
  assign fp_pick = mid_t'(rr_find_first(RR_MAX_MASTERS'(m_valid), 32'd0, NUM_MASTERS));

  // A stalled grant is pinned so the slave sees stable request fields.
  always_comb begin
    gnt = fp_pick;
    if (lock_q)           gnt = lock_id_q;
    else if (ROUND_ROBIN) gnt = rr_pick;
  end

  // A full tracker blocks the request outright; a same-cycle pop does not
  // unblock it because full is a registered status.
  assign s_valid = !rst && (|m_valid) && !full;
  assign s_addr  = m_addr [gnt*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_wen   = m_wen  [gnt];
  assign s_wdata = m_wdata[gnt*DATA_WIDTH +: DATA_WIDTH];
  assign s_wmask = m_wmask[gnt*MASK_W     +: MASK_W];

  assign accept = s_valid && s_ready;
  assign stall  = s_valid && !s_ready;

  always_comb begin
    m_ready = '0;
    if (!rst && s_ready && !full) m_ready[gnt] = 1'b1;
  end

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      lock_d = 1'b0;
      if (ROUND_ROBIN) rr_ptr_d = (gnt == LAST_ID) ? '0 : gnt + 1'b1;
    end else if (stall) begin
      lock_d    = 1'b1;
      lock_id_d = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  membus_arb_tracker #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (gnt),
    .pop     (s_rvalid),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // Responses return in order, so the tracker head names the owner.
  // A response with nothing outstanding is dropped.
  always_comb begin
    m_rvalid = '0;
    if (!rst && s_rvalid && !empty) m_rvalid[head] = 1'b1;
  end
  assign m_rdata = s_rdata;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(s_rvalid && empty))
        else $warning("membus_arbiter: response with no request outstanding was dropped");
      assert (!(lock_q && !m_valid[lock_id_q]))
        else $warning("membus_arbiter: locked master withdrew m_valid before m_ready");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_membus_arbiter                                          |
// | Description : Directed self-checking bench. Instance a: 3 masters,       |
// |               round-robin, depth 4. Instance b: 2 masters, fixed         |
// |               priority, depth 4. Expected values are hand-derived.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_membus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance a: 3 masters, round-robin -----------------
  logic [2:0]  a_m_valid, a_m_ready, a_m_wen, a_m_rvalid;
  logic [95:0] a_m_addr, a_m_wdata;
  logic [11:0] a_m_wmask;
  logic [31:0] a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic        a_s_valid, a_s_wen, a_s_ready, a_s_rvalid;
  logic [3:0]  a_s_wmask;

  membus_arbiter #(
    .NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .MAX_OUTSTANDING(4), .ROUND_ROBIN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_addr(a_m_addr),
    .m_wen(a_m_wen), .m_wdata(a_m_wdata), .m_wmask(a_m_wmask),
    .m_rvalid(a_m_rvalid), .m_rdata(a_m_rdata),
    .s_valid(a_s_valid), .s_addr(a_s_addr), .s_wen(a_s_wen),
    .s_wdata(a_s_wdata), .s_wmask(a_s_wmask), .s_ready(a_s_ready),
    .s_rvalid(a_s_rvalid), .s_rdata(a_s_rdata)
  );

  // ---------------- instance b: 2 masters, fixed priority --------------
  logic [1:0]  b_m_valid, b_m_ready, b_m_wen, b_m_rvalid;
  logic [63:0] b_m_addr, b_m_wdata;
  logic [7:0]  b_m_wmask;
  logic [31:0] b_m_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic        b_s_valid, b_s_wen, b_s_ready, b_s_rvalid;
  logic [3:0]  b_s_wmask;

  membus_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .MAX_OUTSTANDING(4), .ROUND_ROBIN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_addr(b_m_addr),
    .m_wen(b_m_wen), .m_wdata(b_m_wdata), .m_wmask(b_m_wmask),
    .m_rvalid(b_m_rvalid), .m_rdata(b_m_rdata),
    .s_valid(b_s_valid), .s_addr(b_s_addr), .s_wen(b_s_wen),
    .s_wdata(b_s_wdata), .s_wmask(b_s_wmask), .s_ready(b_s_ready),
    .s_rvalid(b_s_rvalid), .s_rdata(b_s_rdata)
  );

  // Per-master request fields, fixed for the whole run.
  function automatic logic [31:0] a_addr_of(input int i);  return 32'h8000_0000 + 32'(i) * 32'h10; endfunction
  function automatic logic [31:0] a_wdata_of(input int i); return 32'h1111_1111 * 32'(i + 1);       endfunction
  function automatic logic [3:0]  a_wmask_of(input int i); return 4'(i + 1);                        endfunction
  function automatic logic [31:0] b_addr_of(input int i);  return 32'h4000_0000 + 32'(i) * 32'h10; endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_m_addr [i*32 +: 32] = a_addr_of(i);
      a_m_wdata[i*32 +: 32] = a_wdata_of(i);
      a_m_wmask[i*4  +: 4]  = a_wmask_of(i);
    end
    a_m_wen = 3'b010;
    for (int i = 0; i < 2; i++) begin
      b_m_addr [i*32 +: 32] = b_addr_of(i);
      b_m_wdata[i*32 +: 32] = 32'h5500_0000 + 32'(i);
      b_m_wmask[i*4  +: 4]  = 4'hF - 4'(i);
    end
    b_m_wen = 2'b10;

    // ---- reset: outputs held low even with requests and responses present
    rst = 1'b1;
    a_m_valid = 3'b111; a_s_ready = 1'b1; a_s_rvalid = 1'b1; a_s_rdata = 32'h0;
    b_m_valid = 2'b11;  b_s_ready = 1'b1; b_s_rvalid = 1'b0; b_s_rdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_a_m_ready",  a_m_ready,  3'b000);
      chk("rst_a_s_valid",  a_s_valid,  1'b0);
      chk("rst_a_m_rvalid", a_m_rvalid, 3'b000);
      chk("rst_b_s_valid",  b_s_valid,  1'b0);
      step();
    end
    rst = 1'b0;
    a_m_valid = 3'b000; a_s_rvalid = 1'b0;
    b_m_valid = 2'b00;

    // ---- round-robin fairness with response one cycle after each accept;
    //      from k=1 every cycle is a simultaneous push and pop
    for (int k = 0; k < 7; k++) begin
      a_m_valid  = (k < 6) ? 3'b111 : 3'b000;
      a_s_ready  = 1'b1;
      a_s_rvalid = (k > 0);
      a_s_rdata  = 32'hA0 + 32'(k) - 32'd1;
      #1;
      if (k < 6) begin
        chk("rr_s_valid", a_s_valid, 1'b1);
        chk("rr_m_ready", a_m_ready, 3'b001 << (k % 3));
        chk("rr_s_addr",  a_s_addr,  a_addr_of(k % 3));
        chk("rr_s_wen",   a_s_wen,   (k % 3) == 1);
        chk("rr_s_wdata", a_s_wdata, a_wdata_of(k % 3));
        chk("rr_s_wmask", a_s_wmask, a_wmask_of(k % 3));
      end
      if (k > 0) begin
        chk("rr_m_rvalid", a_m_rvalid, 3'b001 << ((k - 1) % 3));
        chk("rr_m_rdata",  a_m_rdata,  32'hA0 + 32'(k) - 32'd1);
      end
      step();
    end
    a_s_rvalid = 1'b0;

    // ---- stall lock: master 1 granted, master 0 joins while stalled
    a_m_valid = 3'b010; a_s_ready = 1'b0; #1;
    chk("lock_s_addr_c0", a_s_addr, 32'h8000_0010);
    chk("lock_m_ready_c0", a_m_ready, 3'b000);
    step(); #1;
    chk("lock_s_addr_c1", a_s_addr, 32'h8000_0010);
    step();
    a_m_valid = 3'b011; #1;
    chk("lock_s_addr_c2", a_s_addr, 32'h8000_0010);
    chk("lock_m_ready_c2", a_m_ready, 3'b000);
    step();
    a_s_ready = 1'b1; #1;
    chk("lock_accept_addr",  a_s_addr,  32'h8000_0010);
    chk("lock_accept_ready", a_m_ready, 3'b010);
    step();
    // rr_ptr now 2; master 2 idle, so the scan wraps to master 0
    a_m_valid = 3'b001; #1;
    chk("after_lock_ready", a_m_ready, 3'b001);
    chk("after_lock_addr",  a_s_addr,  32'h8000_0000);
    step();
    a_m_valid = 3'b000; a_s_rvalid = 1'b1; a_s_rdata = 32'hB0; #1;
    chk("lock_resp0", a_m_rvalid, 3'b010);
    step();
    a_s_rdata = 32'hB1; #1;
    chk("lock_resp1", a_m_rvalid, 3'b001);
    chk("lock_rdata1", a_m_rdata, 32'hB1);
    step();
    a_s_rvalid = 1'b0;

    // ---- full tracker: four accepts, then blocked
    a_m_valid = 3'b100; a_s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_s_valid", a_s_valid, 1'b1);
      chk("fill_m_ready", a_m_ready, 3'b100);
      step();
    end
    #1;
    chk("full_s_valid", a_s_valid, 1'b0);
    chk("full_m_ready", a_m_ready, 3'b000);
    step();
    a_s_rvalid = 1'b1; a_s_rdata = 32'hC0; #1;
    chk("full_pop_s_valid", a_s_valid, 1'b0);
    chk("full_pop_rvalid",  a_m_rvalid, 3'b100);
    chk("full_pop_rdata",   a_m_rdata,  32'hC0);
    step();
    a_s_rvalid = 1'b0; #1;
    chk("resume_s_valid", a_s_valid, 1'b1);
    chk("resume_m_ready", a_m_ready, 3'b100);
    step();
    a_m_valid = 3'b000; a_s_rvalid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      a_s_rdata = 32'hC1 + 32'(j); #1;
      chk("drain_rvalid", a_m_rvalid, 3'b100);
      step();
    end

    // ---- spurious response with empty tracker is dropped
    #1;
    chk("spurious_rvalid", a_m_rvalid, 3'b000);
    step();
    a_s_rvalid = 1'b0; a_m_valid = 3'b001; #1;
    chk("post_spur_ready", a_m_ready, 3'b001);
    step();
    a_m_valid = 3'b000; a_s_rvalid = 1'b1; a_s_rdata = 32'hD0; #1;
    chk("post_spur_rvalid", a_m_rvalid, 3'b001);
    step();
    a_s_rvalid = 1'b0;

    // ---- fixed priority: master 0 wins every time both request
    b_m_valid = 2'b11; b_s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_m_ready", b_m_ready, 2'b01);
      chk("fp_s_addr",  b_s_addr,  b_addr_of(0));
      step();
    end
    #1;
    chk("fp_full_s_valid", b_s_valid, 1'b0);
    step();
    b_m_valid = 2'b10; b_s_rvalid = 1'b1; b_s_rdata = 32'hE0; #1;
    chk("fp_pop_s_valid", b_s_valid,  1'b0);
    chk("fp_pop_rvalid",  b_m_rvalid, 2'b01);
    step();
    b_s_rdata = 32'hE1; #1;
    chk("fp_m1_ready",  b_m_ready, 2'b10);
    chk("fp_m1_addr",   b_s_addr,  b_addr_of(1));
    chk("fp_m1_wen",    b_s_wen,   1'b1);
    chk("fp_m1_wdata",  b_s_wdata, 32'h5500_0001);
    chk("fp_m1_wmask",  b_s_wmask, 4'hE);
    chk("fp_m1_rvalid", b_m_rvalid, 2'b01);
    chk("fp_m1_rdata",  b_m_rdata, 32'hE1);
    step();
    b_m_valid = 2'b00;
    #1; chk("fp_drain0", b_m_rvalid, 2'b01); step();
    #1; chk("fp_drain1", b_m_rvalid, 2'b01); step();
    #1; chk("fp_drain2", b_m_rvalid, 2'b10); step();
    b_s_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
